// File: rtl/pe_packetizer.sv
// pe_packetizer: accumulates up to ACC_N unsigned partial sums into a
// saturating payload, wraps it in a {dest, src, type} header and hands one
// packet at a time to the downstream fanout stage over valid/ready.
// The accumulator and the output register are separate stages, so a closed
// packet can wait in the accumulator (HOLD) while the output register stalls.
module pe_packetizer #(
  parameter int WIDTH_packet = 28,
  parameter int WIDTH_pay    = 18,
  parameter int WIDTH_in     = 8,
  parameter int ACC_N        = 4,
  parameter int SRC_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_in-1:0]     in_data,
  input  logic                    in_last,
  input  logic [3:0]              cfg_dest,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH_packet-1:0] out_packet,
  output logic [7:0]              pkt_count
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] L_ACC_N  = 8'(ACC_N);
  localparam logic [3:0] L_SRC    = 4'(SRC_ID);
  localparam logic [1:0] T_FULL   = 2'b01;
  localparam logic [1:0] T_FLUSH  = 2'b10;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [WIDTH_pay-1:0]    r_acc_sum;
  logic [7:0]              r_acc_cnt;
  logic [3:0]              r_hold_dest;
  logic [1:0]              r_hold_type;

  logic                    r_out_valid;
  logic [WIDTH_packet-1:0] r_out_packet;
  logic [7:0]              r_pkt_count;

  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_out_free;
  logic [WIDTH_pay:0]      w_sum_wide;
  logic [WIDTH_pay-1:0]    w_sum_next;
  logic [7:0]              w_cnt_next;
  logic                    w_full;
  logic                    w_close;
  logic [1:0]              w_type;
  logic [WIDTH_packet-1:0] w_close_pkt;
  logic [WIDTH_packet-1:0] w_hold_pkt;

  logic                    w_in_ready;
  logic                    w_load_out;
  logic [WIDTH_packet-1:0] w_load_pkt;
  logic                    w_acc_clear;
  logic                    w_acc_step;
  logic                    w_acc_hold;

  // Transfer qualifiers; input acceptance depends only on the registered state.
  assign w_in_fire  = in_valid && (r_state == S_ACCUM);
  assign w_out_fire = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Saturating add: one extra bit catches the carry, which clamps to all-ones.
  assign w_sum_wide = {1'b0, r_acc_sum} + (WIDTH_pay + 1)'(in_data);
  assign w_sum_next = w_sum_wide[WIDTH_pay] ? {WIDTH_pay{1'b1}} : w_sum_wide[WIDTH_pay-1:0];
  assign w_cnt_next = r_acc_cnt + 8'd1;

  // A word that reaches ACC_N is a full packet even if in_last is also set.
  assign w_full      = (w_cnt_next == L_ACC_N);
  assign w_close     = w_in_fire && (w_full || in_last);
  assign w_type      = w_full ? T_FULL : T_FLUSH;
  assign w_close_pkt = {cfg_dest, L_SRC, w_type, w_sum_next};
  assign w_hold_pkt  = {r_hold_dest, L_SRC, r_hold_type, r_acc_sum};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: park a closed packet in HOLD until the output register drains.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: if (w_close && !w_out_free) w_state_next = S_HOLD;
      S_HOLD:  if (w_out_fire)             w_state_next = S_ACCUM;
      default: w_state_next = S_ACCUM;
    endcase
  end

  // Per-state controls for the accumulator and the output register.
  always_comb begin
    w_in_ready  = 1'b0;
    w_load_out  = 1'b0;
    w_load_pkt  = w_close_pkt;
    w_acc_clear = 1'b0;
    w_acc_step  = 1'b0;
    w_acc_hold  = 1'b0;
    case (r_state)
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (w_close && w_out_free) begin
          w_load_out  = 1'b1;
          w_acc_clear = 1'b1;
        end else if (w_close) begin
          w_acc_hold = 1'b1;
        end else if (w_in_fire) begin
          w_acc_step = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_out_fire) begin
          w_load_out  = 1'b1;
          w_load_pkt  = w_hold_pkt;
          w_acc_clear = 1'b1;
        end
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Accumulator: running sum/count, plus header fields of a packet parked in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_sum   <= '0;
      r_acc_cnt   <= '0;
      r_hold_dest <= '0;
      r_hold_type <= '0;
    end else if (w_acc_clear) begin
      r_acc_sum <= '0;
      r_acc_cnt <= '0;
    end else if (w_acc_step) begin
      r_acc_sum <= w_sum_next;
      r_acc_cnt <= w_cnt_next;
    end else if (w_acc_hold) begin
      r_acc_sum   <= w_sum_next;
      r_acc_cnt   <= w_cnt_next;
      r_hold_dest <= cfg_dest;
      r_hold_type <= w_type;
    end
  end

  // Output register: a load only happens when it is empty or draining this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_packet <= '0;
    end else if (w_load_out) begin
      r_out_valid  <= 1'b1;
      r_out_packet <= w_load_pkt;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Delivered-packet counter, wrapping modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
    end else if (w_out_fire) begin
      r_pkt_count <= r_pkt_count + 8'd1;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_packet = r_out_packet;
  assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_pe_packetizer.sv
// Bench for pe_packetizer: three instances (default, 9-bit payload, ACC_N=1)
// driven side by side and compared every cycle against a queue-based model.
module tb_pe_packetizer;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [ND];
  logic       in_last   [ND];
  logic       out_ready [ND];
  logic [7:0] in_data   [ND];
  logic [3:0] cfg_dest  [ND];
  logic       in_ready  [ND];
  logic       out_valid [ND];
  logic [27:0] out_packet [ND];
  logic [7:0] pkt_count [ND];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      localparam int PAY = (gi == 1) ? 9 : 18;
      localparam int ACC = (gi == 2) ? 1 : 4;
      logic [PAY+9:0] w_pkt;
      pe_packetizer #(
        .WIDTH_packet(PAY + 10), .WIDTH_pay(PAY), .WIDTH_in(8),
        .ACC_N(ACC), .SRC_ID(0)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
        .in_data(in_data[gi]), .in_last(in_last[gi]),
        .cfg_dest(cfg_dest[gi]),
        .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
        .out_packet(w_pkt), .pkt_count(pkt_count[gi])
      );
      assign out_packet[gi] = 28'(w_pkt);
    end
  endgenerate

  // Reference model: packets waiting downstream of the accumulator (output
  // register + at most one held), plus the running sum of the open packet.
  logic [27:0] mq [ND][$];
  logic [27:0] mlast [ND];
  longint      msum [ND];
  int          mcnt [ND];
  int          mpc  [ND];
  int          mdel [ND];
  int          errors = 0;
  int          checks = 0;

  function automatic int pay_w(int k);
    return (k == 1) ? 9 : 18;
  endfunction

  function automatic int acc_n(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic logic [27:0] make_pkt(int k, logic [3:0] dest, bit full, longint sum);
    int     pw;
    longint cap;
    longint pay;
    longint v;
    pw  = pay_w(k);
    cap = (longint'(1) << pw) - 1;
    pay = (sum > cap) ? cap : sum;
    v   = (longint'(dest) << (pw + 6)) | (longint'(full ? 1 : 2) << pw) | pay;
    return v[27:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < ND; k++) begin
      mq[k].delete();
      mlast[k] = '0;
      msum[k]  = 0;
      mcnt[k]  = 0;
      mpc[k]   = 0;
      mdel[k]  = 0;
    end
  endtask

  // Applies the inputs currently driven to the model for the coming edge.
  task automatic model_step();
    for (int k = 0; k < ND; k++) begin
      int sz;
      bit ofire;
      bit ifire;
      sz    = mq[k].size();
      ofire = (sz > 0) && out_ready[k];
      ifire = in_valid[k] && (sz < 2);
      if (ofire) begin
        mlast[k] = mq[k].pop_front();
        mpc[k]   = (mpc[k] + 1) % 256;
        mdel[k]++;
      end
      if (ifire) begin
        msum[k] += longint'(in_data[k]);
        mcnt[k]++;
        if (mcnt[k] == acc_n(k) || in_last[k]) begin
          mq[k].push_back(make_pkt(k, cfg_dest[k], mcnt[k] == acc_n(k), msum[k]));
          msum[k] = 0;
          mcnt[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < ND; k++) begin
      check($sformatf("d%0d in_ready", k), 32'(in_ready[k]), 32'(mq[k].size() < 2));
      check($sformatf("d%0d out_valid", k), 32'(out_valid[k]), 32'(mq[k].size() > 0));
      check($sformatf("d%0d out_packet", k), 32'(out_packet[k]),
            32'((mq[k].size() > 0) ? mq[k][0] : mlast[k]));
      check($sformatf("d%0d pkt_count", k), 32'(pkt_count[k]), 32'(mpc[k]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    for (int k = 0; k < ND; k++) begin
      in_valid[k]  = 1'b0;
      in_last[k]   = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
      cfg_dest[k]  = 4'd3;
    end
  endtask

  task automatic drive(input int k, input logic [7:0] d, input logic last);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_last[k]  = last;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("d%0d rst in_ready", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("d%0d rst out_valid", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("d%0d rst out_packet", k), 32'(out_packet[k]), 32'd0);
      check($sformatf("d%0d rst pkt_count", k), 32'(pkt_count[k]), 32'd0);
    end
    model_clear();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit wrap_seen;
    rst_n = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();

    // Full packet of 10+20+30+40 to dest 3.
    out_ready[0] = 1'b1;
    drive(0, 8'd10, 1'b0); cycle();
    drive(0, 8'd20, 1'b0); cycle();
    drive(0, 8'd30, 1'b0); cycle();
    drive(0, 8'd40, 1'b0); cycle();
    in_valid[0] = 1'b0;
    check("t1 valid", 32'(out_valid[0]), 32'd1);
    check("t1 packet", 32'(out_packet[0]), 32'({4'd3, 4'd0, 2'b01, 18'd100}));
    cycle();
    check("t1 count", 32'(pkt_count[0]), 32'd1);

    // Early flush 5+7, then a fresh full packet starting from zero.
    drive(0, 8'd5, 1'b0); cycle();
    drive(0, 8'd7, 1'b1); cycle();
    in_valid[0] = 1'b0;
    check("t2 flush", 32'(out_packet[0]), 32'({4'd3, 4'd0, 2'b10, 18'd12}));
    for (int i = 1; i <= 4; i++) begin
      drive(0, 8'(i), 1'b0);
      cycle();
    end
    in_valid[0] = 1'b0;
    check("t2 fresh", 32'(out_packet[0]), 32'({4'd3, 4'd0, 2'b01, 18'd10}));
    cycle();

    // Saturation on the 9-bit payload instance.
    out_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'd255, 1'b0);
      cycle();
    end
    in_valid[1] = 1'b0;
    check("t3 saturate", 32'(out_packet[1]), 32'({4'd3, 4'd0, 2'b01, 9'd511}));
    cycle();

    // Backpressure: 9 words of 1 with out_ready low; the ninth must wait.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(0, 8'd1, 1'b0);
      cycle();
    end
    check("t4 hold in_ready", 32'(in_ready[0]), 32'd0);
    check("t4 hold valid", 32'(out_valid[0]), 32'd1);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    cycle();
    check("t4 second valid", 32'(out_valid[0]), 32'd1);
    check("t4 second packet", 32'(out_packet[0]), 32'({4'd3, 4'd0, 2'b01, 18'd4}));
    check("t4 exit in_ready", 32'(in_ready[0]), 32'd1);
    cycle();
    check("t4 drained", 32'(out_valid[0]), 32'd0);

    // ACC_N=1: a word with in_last is still a full packet; one packet per cycle.
    out_ready[2] = 1'b1;
    drive(2, 8'd9, 1'b1); cycle();
    check("t5 type", 32'(out_packet[2]), 32'({4'd3, 4'd0, 2'b01, 18'd9}));
    for (int i = 0; i < 6; i++) begin
      drive(2, 8'($urandom_range(0, 255)), 1'b0);
      cycle();
      check("t5 streaming", 32'(out_valid[2]), 32'd1);
    end
    idle();
    cycle();

    // Reset with a packet pending in the output register and two words open.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 8'd50, 1'b0);
      cycle();
    end
    do_reset();
    out_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 8'(i), 1'b0);
      cycle();
    end
    in_valid[0] = 1'b0;
    check("t6 post reset", 32'(out_packet[0]), 32'({4'd3, 4'd0, 2'b01, 18'd10}));

    // 256 deliveries wrap the packet counter.
    wrap_seen    = 1'b0;
    out_ready[2] = 1'b1;
    for (int i = 0; i < 270; i++) begin
      drive(2, 8'(i), 1'b0);
      cycle();
      if (mdel[2] == 256 && !wrap_seen) begin
        wrap_seen = 1'b1;
        check("t6 wrap", 32'(pkt_count[2]), 32'd0);
      end
    end
    check("t6 wrap reached", 32'(wrap_seen), 32'd1);
    idle();
    cycle();

    // Randomized traffic on all instances, with a reset dropped in midway.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < ND; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_last[k]   = ($urandom_range(0, 5) == 0);
        out_ready[k] = ($urandom_range(0, 2) != 0);
        cfg_dest[k]  = 4'($urandom_range(0, 15));
        in_data[k]   = (k == 1 && $urandom_range(0, 1) == 1) ? 8'd255
                                                              : 8'($urandom_range(0, 255));
      end
      cycle();
      if (c == 700) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
